mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 156 +++++++++++++++
 tb/tb_mem_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: two-port cache-line arbiter in front of one shared memory port.
// A request is latched in IDLE, held on the memory bus in MEM0/MEM1 until
// mem_ready, and acknowledged with a one-cycle ready pulse in RESP.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking.
// Without it, port 0 always wins a tie.
`timescale 1ns/1ps

module mem_arb #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              r,
  input  logic              c0_valid,
  input  logic              c1_valid,
  input  logic              c0_rw,
  input  logic              c1_rw,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [LINE_W-1:0] c0_wdata,
  input  logic [LINE_W-1:0] c1_wdata,
  output logic [LINE_W-1:0] c0_rdata,
  output logic [LINE_W-1:0] c1_rdata,
  output logic              c0_ready,
  output logic              c1_ready,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, MEM0, MEM1, RESP} state_t;

  state_t              state_reg, state_next;
  logic                grant_reg, grant_next;
  logic                rw_reg, rw_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [LINE_W-1:0]   wdata_reg, wdata_next;
  logic                grant_fire;
  logic                grant_sel;
  logic                tie_port;

  // Per-port views of the request inputs so the grant mux can index by port.
  logic [1:0]          valid_vec;
  logic [1:0]          rw_vec;
  logic [ADDR_W-1:0]   addr_vec  [2];
  logic [LINE_W-1:0]   wdata_vec [2];
  logic [LINE_W-1:0]   rdata_vec [2];
  logic [1:0]          ready_vec;

  assign valid_vec    = {c1_valid, c0_valid};
  assign rw_vec       = {c1_rw, c0_rw};
  assign addr_vec[0]  = c0_addr;
  assign addr_vec[1]  = c1_addr;
  assign wdata_vec[0] = c0_wdata;
  assign wdata_vec[1] = c1_wdata;

`ifdef MEM_ARB_RR_EN
  logic ptr_reg, ptr_next;

  // The pointer flips on every grant, so a persistent tie alternates ports.
  always_comb begin
    ptr_next = ptr_reg;
    if (grant_fire) ptr_next = ~ptr_reg;
  end

  // Pointer register; port 0 has priority out of reset.
  always_ff @(posedge clk) begin
    if (r) ptr_reg <= 1'b0;
    else   ptr_reg <= ptr_next;
  end

  assign tie_port = ptr_reg;
`else
  assign tie_port = 1'b0;
`endif

  // Next-state and request-latch logic; fields are only sampled in IDLE,
  // so requester changes after the grant cannot disturb the memory bus.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    rw_next    = rw_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    grant_fire = 1'b0;
    grant_sel  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|valid_vec) begin
          grant_fire = 1'b1;
          grant_sel  = (&valid_vec) ? tie_port : valid_vec[1];
          grant_next = grant_sel;
          rw_next    = rw_vec[grant_sel];
          addr_next  = addr_vec[grant_sel];
          wdata_next = wdata_vec[grant_sel];
          state_next = grant_sel ? MEM1 : MEM0;
        end
      end
      MEM0, MEM1: begin
        if (mem_ready) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control state and latched memory request.
  always_ff @(posedge clk) begin
    if (r) begin
      state_reg <= IDLE;
      grant_reg <= 1'b0;
      rw_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      rw_reg    <= rw_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_port
      localparam state_t MEM_ST = (gi == 0) ? MEM0 : MEM1;
      logic [LINE_W-1:0] rdata_reg;

      // Read line is captured as memory completes and held until the next
      // read on this port; writes leave it untouched.
      always_ff @(posedge clk) begin
        if (r)
          rdata_reg <= '0;
        else if (state_reg == MEM_ST && mem_ready && !rw_reg)
          rdata_reg <= mem_rdata;
      end

      assign rdata_vec[gi] = rdata_reg;
      assign ready_vec[gi] = (state_reg == RESP) && (grant_reg == 1'(gi));
    end
  endgenerate

  assign c0_rdata  = rdata_vec[0];
  assign c1_rdata  = rdata_vec[1];
  assign c0_ready  = ready_vec[0];
  assign c1_ready  = ready_vec[1];
  assign mem_valid = (state_reg == MEM0) || (state_reg == MEM1);
  assign mem_rw    = rw_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed checks of mem_arb with hand-computed expectations.
`timescale 1ns/1ps

module tb_mem_arb;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              r;
  logic              c0_valid, c1_valid, c0_rw, c1_rw;
  logic [ADDR_W-1:0] c0_addr, c1_addr;
  logic [LINE_W-1:0] c0_wdata, c1_wdata;
  logic [LINE_W-1:0] c0_rdata, c1_rdata;
  logic              c0_ready, c1_ready;
  logic              mem_valid, mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata, mem_rdata;
  logic              mem_ready;

  int errors = 0;
  int checks = 0;

  localparam logic [LINE_W-1:0] LINE_A5 = {16{8'hA5}};
  localparam logic [LINE_W-1:0] LINE_FF = {LINE_W{1'b1}};

  mem_arb #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .r(r),
    .c0_valid(c0_valid), .c1_valid(c1_valid),
    .c0_rw(c0_rw), .c1_rw(c1_rw),
    .c0_addr(c0_addr), .c1_addr(c1_addr),
    .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
    .c0_rdata(c0_rdata), .c1_rdata(c1_rdata),
    .c0_ready(c0_ready), .c1_ready(c1_ready),
    .mem_valid(mem_valid), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting in an IDLE cycle with requests presented: expect the given port
  // to be granted, answer with mem_ready at once, and check the ready pulse.
  task automatic serve(input string tag, input logic exp_port,
                       input logic [ADDR_W-1:0] exp_addr,
                       input logic [LINE_W-1:0] line);
    tick();
    check({tag, " mem_valid"}, LINE_W'(mem_valid), LINE_W'(1));
    check({tag, " mem_addr"}, LINE_W'(mem_addr), LINE_W'(exp_addr));
    mem_ready = 1'b1;
    mem_rdata = line;
    tick();
    mem_ready = 1'b0;
    check({tag, " c0_ready"}, LINE_W'(c0_ready), LINE_W'(!exp_port));
    check({tag, " c1_ready"}, LINE_W'(c1_ready), LINE_W'(exp_port));
    check({tag, " rdata"}, exp_port ? c1_rdata : c0_rdata, line);
    tick();
  endtask

  initial begin
    r = 1'b1;
    c0_valid = 0; c1_valid = 0; c0_rw = 0; c1_rw = 0;
    c0_addr = '0; c1_addr = '0; c0_wdata = '0; c1_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    tick();
    tick();
    check("rst mem_valid", LINE_W'(mem_valid), '0);
    check("rst mem_rw", LINE_W'(mem_rw), '0);
    check("rst mem_addr", LINE_W'(mem_addr), '0);
    check("rst mem_wdata", mem_wdata, '0);
    check("rst c0_ready", LINE_W'(c0_ready), '0);
    check("rst c1_ready", LINE_W'(c1_ready), '0);
    check("rst c0_rdata", c0_rdata, '0);
    check("rst c1_rdata", c1_rdata, '0);

    // Single read on port 0, memory answers in the second MEM0 cycle.
    r = 1'b0;
    c0_valid = 1; c0_rw = 0; c0_addr = 32'h0;
    tick();
    check("rd mem_valid c1", LINE_W'(mem_valid), LINE_W'(1));
    check("rd mem_rw", LINE_W'(mem_rw), '0);
    check("rd mem_addr", LINE_W'(mem_addr), '0);
    tick();
    check("rd mem_valid c2", LINE_W'(mem_valid), LINE_W'(1));
    check("rd no early ready", LINE_W'(c0_ready), '0);
    mem_ready = 1; mem_rdata = LINE_A5;
    tick();
    mem_ready = 0; mem_rdata = '0;
    check("rd resp mem_valid", LINE_W'(mem_valid), '0);
    check("rd c0_ready", LINE_W'(c0_ready), LINE_W'(1));
    check("rd c1_ready", LINE_W'(c1_ready), '0);
    check("rd c0_rdata", c0_rdata, LINE_A5);
    c0_valid = 0;
    tick();
    check("rd pulse ends", LINE_W'(c0_ready), '0);
    check("rd rdata held", c0_rdata, LINE_A5);

    // Single write on port 1.
    c1_valid = 1; c1_rw = 1; c1_addr = 32'h0000_4100; c1_wdata = LINE_FF;
    tick();
    check("wr mem_valid", LINE_W'(mem_valid), LINE_W'(1));
    check("wr mem_rw", LINE_W'(mem_rw), LINE_W'(1));
    check("wr mem_addr", LINE_W'(mem_addr), LINE_W'(32'h0000_4100));
    check("wr mem_wdata", mem_wdata, LINE_FF);
    mem_ready = 1; mem_rdata = 128'h1234;
    tick();
    mem_ready = 0;
    check("wr c1_ready", LINE_W'(c1_ready), LINE_W'(1));
    check("wr c0_ready", LINE_W'(c0_ready), '0);
    check("wr c1_rdata", c1_rdata, '0);
    c1_valid = 0; c1_rw = 0;
    tick();

    // Stray mem_ready in IDLE.
    mem_ready = 1; mem_rdata = 128'hDEAD;
    tick();
    check("stray mem_valid", LINE_W'(mem_valid), '0);
    check("stray c0_ready", LINE_W'(c0_ready), '0);
    tick();
    check("stray c1_ready", LINE_W'(c1_ready), '0);
    check("stray c0_rdata", c0_rdata, LINE_A5);
    mem_ready = 0;

    // c1 arrives while c0 is in MEM0; it is issued after c0 completes.
    c0_valid = 1; c0_addr = 32'h100;
    tick();
    c1_valid = 1; c1_addr = 32'h200;
    tick();
    check("ovl c0 addr kept", LINE_W'(mem_addr), LINE_W'(32'h100));
    mem_ready = 1; mem_rdata = {16{8'h11}};
    tick();
    mem_ready = 0;
    check("ovl c0_ready", LINE_W'(c0_ready), LINE_W'(1));
    check("ovl c1 waits", LINE_W'(c1_ready), '0);
    c0_valid = 0;
    tick();
    check("ovl idle mem_valid", LINE_W'(mem_valid), '0);
    c1_addr = 32'h200;
    serve("ovl c1", 1'b1, 32'h200, {16{8'h22}});
    check("ovl c0_rdata kept", c0_rdata, {16{8'h11}});
    c1_valid = 0;

    // Tie arbitration, starting from a fresh pointer.
    r = 1;
    tick();
    r = 0;
    c0_valid = 1; c0_addr = 32'h1000;
    c1_valid = 1; c1_addr = 32'h2000;
`ifdef MEM_ARB_RR_EN
    for (int i = 0; i < 6; i++) begin
      logic p;
      p = logic'(i % 2);
      serve($sformatf("rr%0d", i), p,
            (p ? 32'h2000 : 32'h1000) + 32'(4 * (i / 2)), 128'(i + 1));
      if (p) c1_addr = c1_addr + 4;
      else   c0_addr = c0_addr + 4;
      if (i == 4) c0_valid = 0;
    end
    c1_valid = 0;
`else
    for (int i = 0; i < 3; i++) begin
      serve($sformatf("fix%0d", i), 1'b0, 32'h1000 + 32'(4 * i), 128'(i + 1));
      c0_addr = c0_addr + 4;
    end
    c0_valid = 0;
    serve("fix c1", 1'b1, 32'h2000, 128'h77);
    c1_valid = 0;
`endif

    // Reset while port 1 waits in MEM1 with no memory response.
    c1_valid = 1; c1_rw = 0; c1_addr = 32'h300;
    tick();
    check("rstm mem_valid", LINE_W'(mem_valid), LINE_W'(1));
    check("rstm mem_addr", LINE_W'(mem_addr), LINE_W'(32'h300));
    tick();
    r = 1; c1_valid = 0;
    tick();
    check("rstm drop valid", LINE_W'(mem_valid), '0);
    check("rstm no c1_ready", LINE_W'(c1_ready), '0);
    check("rstm addr clear", LINE_W'(mem_addr), '0);
    r = 0;
    tick();
    check("rstm still idle", LINE_W'(mem_valid), '0);
    check("rstm no late ready", LINE_W'(c1_ready), '0);
    c1_valid = 1; c1_addr = 32'h304;
    serve("rstm next", 1'b1, 32'h304, 128'hCAFE);
    c1_valid = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so a stuck bench still terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
